maxnet_engine: RTL and testbench
================================

# maxnet_engine

Parametrised winner-take-all (Maxnet) engine. It generalises the fixed 4-channel Maxnet datapath to N channels with configurable width and a runtime inhibition weight. Activations stream in over a valid/ready port, and the engine iterates mutual inhibition until at most one channel is nonzero. It then reports the winning index plus tie and timeout status, and sits between the activation memory and the classifier controller.

## Interface
Parameters:
- N, 4, channel count (≥2)
- W, 16, activation width, unsigned integer
- FRAC, 8, fraction bits of eps (eps = eps_in / 2^FRAC, unsigned Q0.FRAC, <1)
- MAX_ITER, 255, iteration cap (≥1)

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- eps_in  in  FRAC  inhibition weight, sampled on the first accepted sample of a load
- in_valid  in  1  activation sample valid
- in_ready  out  1  engine accepts a sample (LOAD state only)
- in_data  in  W  activation, channel order 0..N-1
- busy  out  1  high in every state except LOAD
- done  out  1  one-cycle result pulse
- winner  out  $clog2(N)  winning channel index
- win_value  out  W  final activation of winner (0 on tie)
- tie  out  1  no single survivor (all zero)
- timeout  out  1  MAX_ITER reached with ≥2 survivors
- iter_count  out  $clog2(MAX_ITER+1)  update iterations performed

## Operation
States: LOAD, CHECK, SUM, UPDATE, DONE.

- **LOAD:** in_ready=1.
  - Each handshake (in_valid&in_ready) writes x[k] and increments k.
  - Handshake with k=N-1: clear k, iter=0, prev_mask=0, go to CHECK.
  - Result outputs hold their previous values until the first handshake of a new load, which clears them.
- **CHECK:** cnt = number of nonzero x.
  - cnt=1 → DONE: winner = that index, win_value = x[winner].
  - cnt=0 → DONE: tie=1, winner = lowest set bit of prev_mask (0 if prev_mask=0), win_value=0.
  - iter=MAX_ITER → DONE: timeout=1, winner = lowest-index nonzero channel, win_value = its x.
  - Otherwise → SUM.
- **SUM:** S <= Σ x[j], width W+$clog2(N), no overflow possible.
- **UPDATE:** for all i in parallel:
  - p_i = (eps·(S−x_i)) >> FRAC, truncating.
  - x_i <= (p_i ≥ x_i) ? 0 : x_i − p_i.
  - prev_mask <= nonzero mask before update; iter++; go to CHECK.
- **DONE:** done=1 for one cycle, then LOAD.
- in_valid outside LOAD is ignored. No sample is lost, since in_ready=0.
- Reset (async, any state): state=LOAD, k=0, all x/S/iter/prev_mask=0. Outputs reset to in_ready=0 during reset then 1, busy=0, done=0, winner=0, win_value=0, tie=0, timeout=0, iter_count=0.

## Timing
- One sample per cycle max in LOAD; N handshakes per load.
- Last handshake at edge T → CHECK in cycle T+1.
- Each iteration costs 3 cycles (CHECK, SUM, UPDATE).
- done is high in cycle T+2+3·iter_count. Worst case T+2+3·MAX_ITER.
- in_ready rises in the cycle after done.
- Result outputs are stable from done until the next load's first handshake.

## Structure
- Package maxnet_pkg holds:
  - state enum
  - CW=$clog2(N), SW=W+$clog2(N), IW=$clog2(MAX_ITER+1) helper functions
  - lowest-set-bit / popcount functions
- Sub-module maxnet_pe (one per channel, generate loop):
  - holds the x register
  - load, clear and update enables
  - computes p_i and saturating subtract
  - outputs x and nonzero flag
- Top holds FSM, counters, S register, prev_mask, result registers.

## Test plan
Defaults unless stated (N=4, W=16, FRAC=8).
- Load 10,20,30,40, eps_in=64 → after 4 updates x=[0,0,0,21]. Expect done at T+14, winner=3, win_value=21, iter_count=4, tie=0, timeout=0.
- Load 10,10,10,10, eps_in=128 → all zero after 1 update. Expect winner=0, tie=1, win_value=0, iter_count=1, done at T+5.
- Load 50,50,0,0, eps_in=255, MAX_ITER=8 → stalls at [1,1,0,0]. Expect timeout=1, winner=0, win_value=1, iter_count=8, done at T+26.
- Load 0,0,7,0 → winner=2, win_value=7, iter_count=0, done at T+2. Load all zeros → tie=1, winner=0, iter_count=0.
- Gap in in_valid mid-load, and in_valid held during busy → samples land in order; no extra samples captured.
- Assert rst low during UPDATE of case 1 → outputs at reset values immediately. Re-run case 1 → identical result.

Source files
------------

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared state encoding and width/bit-scan helpers for the Maxnet engine
package maxnet_pkg;
  typedef enum logic [2:0] {LOAD, CHECK, SUM, UPDATE, DONE} state_t;
  function automatic int cw(input int n);
    return $clog2(n);
  endfunction
  function automatic int sw(input int w, input int n);
    return w + $clog2(n);
  endfunction
  function automatic int iw(input int m);
    return $clog2(m + 1);
  endfunction
  function automatic int popcount(input logic [63:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(m[i]);
    return c;
  endfunction
  function automatic int lowest(input logic [63:0] m);
    int r;
    r = 0;
    for (int i = 63; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/maxnet_pe.sv
// maxnet_pe: one channel activation register with truncating inhibition and saturating subtract
module maxnet_pe #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int SW   = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic            clr,
  input  logic            upd,
  input  logic [W-1:0]    d,
  input  logic [FRAC-1:0] eps,
  input  logic [SW-1:0]   s,
  output logic [W-1:0]    x,
  output logic            nz
);
  logic [SW+FRAC-1:0] prod;
  logic [SW-1:0] p;
  // s always includes x, so the difference never wraps
  assign prod = (SW+FRAC)'(eps) * (SW+FRAC)'(s - SW'(x));
  assign p = SW'(prod >> FRAC);
  assign nz = |x;
  always_ff @(posedge clk or negedge rst)
    if (!rst) x <= '0;
    else if (ld) x <= d;
    else if (clr) x <= '0;
    else if (upd) x <= (p >= SW'(x)) ? '0 : x - W'(p);
endmodule

// File: rtl/maxnet_engine.sv
// maxnet_engine: N-channel winner-take-all engine iterating mutual inhibition until one survivor
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAC-1:0]       eps_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  busy,
  output logic                  done,
  output logic [cw(N)-1:0]      winner,
  output logic [W-1:0]          win_value,
  output logic                  tie,
  output logic                  timeout,
  output logic [iw(MAX_ITER)-1:0] iter_count
);
  localparam int CW = cw(N);
  localparam int SW = sw(W, N);
  localparam int IW = iw(MAX_ITER);
  state_t state, nxt;
  logic [CW-1:0] k, sel;
  logic [IW-1:0] iter;
  logic [SW-1:0] s, sum_c;
  logic [N-1:0] nz, prev_mask;
  logic [W-1:0] x [N];
  logic [FRAC-1:0] eps;
  logic hs, first, last;
  int cnt;
  assign in_ready = rst && state == LOAD;
  assign busy = state != LOAD;
  assign done = state == DONE;
  assign hs = in_valid && in_ready;
  assign first = hs && k == '0;
  assign last = hs && k == CW'(N - 1);
  assign cnt = popcount(64'(nz));
  // an all-zero outcome names the lowest channel that survived the previous round
  assign sel = CW'(lowest(cnt == 0 ? 64'(prev_mask) : 64'(nz)));
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < N; j++) sum_c += SW'(x[j]);
  end
  always_comb begin
    nxt = state;
    case (state)
      LOAD:    nxt = last ? CHECK : LOAD;
      CHECK:   nxt = (cnt <= 1 || iter == IW'(MAX_ITER)) ? DONE : SUM;
      SUM:     nxt = UPDATE;
      UPDATE:  nxt = CHECK;
      default: nxt = LOAD;
    endcase
  end
  for (genvar g = 0; g < N; g++) begin : g_pe
    maxnet_pe #(.W(W), .FRAC(FRAC), .SW(SW)) u_pe (
      .clk(clk), .rst(rst), .ld(hs && k == CW'(g)), .clr(first), .upd(state == UPDATE),
      .d(in_data), .eps(eps), .s(s), .x(x[g]), .nz(nz[g])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= LOAD;
      k <= '0;
      iter <= '0;
      s <= '0;
      prev_mask <= '0;
      eps <= '0;
      winner <= '0;
      win_value <= '0;
      tie <= 1'b0;
      timeout <= 1'b0;
      iter_count <= '0;
    end else begin
      state <= nxt;
      if (hs) k <= last ? '0 : k + CW'(1);
      if (first) begin
        eps <= eps_in;
        winner <= '0;
        win_value <= '0;
        tie <= 1'b0;
        timeout <= 1'b0;
        iter_count <= '0;
      end
      if (last) begin
        iter <= '0;
        prev_mask <= '0;
      end
      if (state == SUM) s <= sum_c;
      if (state == UPDATE) begin
        prev_mask <= nz;
        iter <= iter + IW'(1);
      end
      if (state == CHECK && nxt == DONE) begin
        winner <= sel;
        win_value <= cnt == 0 ? '0 : x[sel];
        tie <= cnt == 0;
        timeout <= cnt > 1;
        iter_count <= iter;
      end
    end
endmodule

// File: tb/tb_maxnet_engine.sv
// tb_maxnet_engine: directed vectors against a default engine and a MAX_ITER=8 engine sharing stimulus
module tb_maxnet_engine;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [7:0] eps_in = '0;
  logic [15:0] in_data = '0;
  logic rdy_a, busy_a, done_a, tie_a, to_a, rdy_b, busy_b, done_b, tie_b, to_b;
  logic [1:0] win_a, win_b;
  logic [15:0] val_a, val_b;
  logic [7:0] it_a;
  logic [3:0] it_b;
  int n_cmp = 0, n_bad = 0, ta, tb;
  always #5 clk = ~clk;
  maxnet_engine dut_a (
    .clk(clk), .rst(rst), .eps_in(eps_in), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .busy(busy_a), .done(done_a), .winner(win_a), .win_value(val_a), .tie(tie_a), .timeout(to_a),
    .iter_count(it_a)
  );
  maxnet_engine #(.MAX_ITER(8)) dut_b (
    .clk(clk), .rst(rst), .eps_in(eps_in), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .busy(busy_b), .done(done_b), .winner(win_b), .win_value(val_b), .tie(tie_b), .timeout(to_b),
    .iter_count(it_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic load(input logic [15:0] v [4], input logic [7:0] e, input bit gap, input bit hold);
    int n;
    for (n = 0; n < 2000 && !(rdy_a && rdy_b); n++) @(negedge clk);
    check("ready_wait", 32'(rdy_a && rdy_b), 1);
    eps_in = e;
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 2) begin
        in_valid = 1'b0;
        in_data = 16'hBEEF;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = v[i];
      @(negedge clk);
      eps_in = ~e;
    end
    in_valid = hold;
    in_data = 16'hDEAD;
    check("busy_after_load", {busy_a, rdy_a}, 2);
  endtask
  task automatic wait_done();
    ta = -1;
    tb = -1;
    for (int n = 1; n <= 1000 && (ta < 0 || tb < 0); n++) begin
      if (done_a && ta < 0) ta = n;
      if (done_b && tb < 0) tb = n;
      if (done_a || done_b) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
  task automatic chk_res(input string tag, input bit b, input int t, input int et, input int ew,
                         input int ev, input int etie, input int eto, input int eit);
    check({tag, "_t"}, 32'(t), et);
    check({tag, "_win"}, b ? 32'(win_b) : 32'(win_a), ew);
    check({tag, "_val"}, b ? 32'(val_b) : 32'(val_a), ev);
    check({tag, "_tie"}, b ? 32'(tie_b) : 32'(tie_a), etie);
    check({tag, "_to"}, b ? 32'(to_b) : 32'(to_a), eto);
    check({tag, "_it"}, b ? 32'(it_b) : 32'(it_a), eit);
  endtask
  task automatic chk_reset(input string tag);
    check({tag, "_rdy"}, 32'(rdy_a), 0);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
    check({tag, "_res"}, {tie_a, to_a, win_a, val_a, it_a}, 0);
  endtask
  initial begin
    logic [15:0] c1 [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
    logic [15:0] c2 [4] = '{16'd10, 16'd10, 16'd10, 16'd10};
    logic [15:0] c3 [4] = '{16'd50, 16'd50, 16'd0, 16'd0};
    logic [15:0] c4 [4] = '{16'd0, 16'd0, 16'd7, 16'd0};
    logic [15:0] c5 [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
    repeat (2) @(negedge clk);
    chk_reset("init");
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(rdy_a), 1);
    load(c1, 8'd64, 1'b0, 1'b1);
    wait_done();
    chk_res("c1a", 1'b0, ta, 14, 3, 21, 0, 0, 4);
    chk_res("c1b", 1'b1, tb, 14, 3, 21, 0, 0, 4);
    load(c2, 8'd128, 1'b0, 1'b0);
    wait_done();
    chk_res("c2a", 1'b0, ta, 5, 0, 0, 1, 0, 1);
    chk_res("c2b", 1'b1, tb, 5, 0, 0, 1, 0, 1);
    load(c3, 8'd255, 1'b0, 1'b0);
    wait_done();
    chk_res("c3a", 1'b0, ta, 767, 0, 1, 0, 1, 255);
    chk_res("c3b", 1'b1, tb, 26, 0, 1, 0, 1, 8);
    load(c4, 8'd64, 1'b1, 1'b0);
    wait_done();
    chk_res("c4a", 1'b0, ta, 2, 2, 7, 0, 0, 0);
    chk_res("c4b", 1'b1, tb, 2, 2, 7, 0, 0, 0);
    load(c1, 8'd64, 1'b0, 1'b0);
    check("c4_held_win", 32'(win_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    load(c1, 8'd64, 1'b1, 1'b0);
    wait_done();
    chk_res("c1ra", 1'b0, ta, 14, 3, 21, 0, 0, 4);
    load(c5, 8'd64, 1'b0, 1'b0);
    wait_done();
    chk_res("c5a", 1'b0, ta, 2, 0, 0, 1, 0, 0);
    chk_res("c5b", 1'b1, tb, 2, 0, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
